// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch-side branch predictor:
// 2-bit counter encodings, branch funct3 codes and the sequential PC step.
package riscv_pkg;

    typedef enum logic [1:0] {
        CTR_SN = 2'b00,
        CTR_WN = 2'b01,
        CTR_WT = 2'b10,
        CTR_ST = 2'b11
    } ctr_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter; it clamps at
// strongly-taken going up and at strongly-not-taken going down.
module bp_sat_counter2
    import riscv_pkg::*;
(
    input  ctr_e ctr,
    input  logic up,
    output ctr_e next
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        next = ctr;
        unique case (ctr)
            CTR_SN: next = up ? CTR_WN : CTR_SN;
            CTR_WN: next = up ? CTR_WT : CTR_SN;
            CTR_WT: next = up ? CTR_ST : CTR_WN;
            CTR_ST: next = up ? CTR_ST : CTR_WT;
            default: next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup,
// EX-stage training, misprediction/redirect generation and perf counters.
module branch_predictor
    import riscv_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int TAG_W   = 30 - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    ctr_e             ctr_next;

    // Instructions are word aligned, so the byte-offset bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // The lookup reads the stored arrays directly: a same-cycle update is not bypassed.
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : 32'd0;

    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                      (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = !ex_valid ? 32'd0 :
                         ex_taken  ? ex_target : ex_pc + PC_STEP;

    bp_sat_counter2 u_ctr (
        .ctr  (ctr_q[ex_idx]),
        .up   (ex_taken),
        .next (ctr_next)
    );

    // NOTE: the table is a flop array precisely so it can be cleared by the async reset; an SRAM could not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WN;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_next;
                if (ex_taken) begin
                    target_q[ex_idx] <= ex_target;
                end
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= CTR_WT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (ex_valid && (branch_cnt != 32'hFFFF_FFFF)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule
